load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage between the RV32I core's execute stage and its data memory.
//  Accepts one load/store at a time and drives a req/gnt/rvalid memory bus.
//  Generates byte strobes and replicated store data, and returns sign/zero-extended load data.
//  Loads return to register write-back as a one-cycle wb_valid pulse; the core stalls on busy.
// PARAMETERS
//  XLEN        32   data/address width (only 32 supported)
//  REG_ADDR_W  5    register index width
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     reset, asynchronous, active-high
//  req_valid  in   1     core presents an access
//  req_ready  out  1     LSU can accept (IDLE only)
//  req_we     in   1     1=store, 0=load
//  req_funct3 in   3     RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr   in   32    byte address (rs1+imm)
//  req_wdata  in   32    store data (rs2)
//  req_rd     in   5     load destination register
//  mem_req    out  1     bus request; held with addr/we/wstrb/wdata stable until mem_gnt
//  mem_we     out  1     bus write
//  mem_addr   out  32    word-aligned address ({req_addr[31:2],2'b00})
//  mem_wstrb  out  4     byte-lane strobes (stores only; 0 on loads)
//  mem_wdata  out  32    lane-replicated store data
//  mem_gnt    in   1     memory accepted request
//  mem_rvalid in   1     response/ack (loads carry mem_rdata); earliest 1 cycle after gnt
//  mem_rdata  in   32    read word
//  wb_valid   out  1     one-cycle load write-back pulse
//  wb_rd      out  5     write-back register
//  wb_data    out  32    extended load data
//  busy       out  1     ~IDLE; core stalls on it
//  misalign   out  1     (LSU_MISALIGN_TRAP_EN only) one-cycle misaligned-access pulse
// BEHAVIOUR
//  Reset: state=IDLE; mem_req, mem_we, wb_valid, busy, misalign=0; mem_addr, mem_wstrb, mem_wdata,
//   wb_rd, wb_data=0.
//  FSM IDLE->REQ->WAIT->IDLE. IDLE: req_ready=1; accept on req_valid, latch all req_* fields,
//   -> REQ. REQ: mem_req=1; on mem_gnt -> WAIT. WAIT: on mem_rvalid -> IDLE; for loads
//   register wb_valid=1, wb_rd, wb_data; wb_valid is high for exactly the next cycle.
//  Stores: no write-back; mem_rvalid is an ack only.
//  Minimum latency (gnt immediate, rvalid 1 cycle after gnt): accept T0, mem_req T1,
//   rvalid T2, wb_valid T3. Accept of the next request is possible in T3 (back-to-back).
//  Lanes (off=addr[1:0]): SB strb=4'b0001<<off, data={4{b}}; SH strb=4'b0011<<{off[1],1'b0},
//   data={2{h}}; SW strb=4'b1111.
//  Loads: LB/LBU select byte off, sign-/zero-extend; LH/LHU select half addr[1]; LW whole word.
//  Illegal funct3 (load 011/110/111, store >=011): accepted, no bus access, no write-back;
//   busy for 1 cycle.
//  mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.
//  Async reset in any state returns to IDLE immediately; mem_req drops without waiting for gnt;
//   any pending response is discarded.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, make no
//   bus access and no write-back, and pulse misalign for 1 cycle the cycle after accept.
//  LSU_MISALIGN_TRAP_EN undefined: no misalign port; halfword ignores addr[0], word ignores
//   addr[1:0].
// STRUCTURE
//  rv32i_pkg: funct3 constants F3_LB..F3_SW, lsu_state_t enum {IDLE,REQ,WAIT}.
//  Sub-module lsu_align (combinational): strobe/store-data generation and load extraction/extension.
// TESTING
//  1 SW 0x3FE @8, gnt immediate -> mem_we=1, mem_addr=0x8, wstrb=1111, wdata=0x3FE; wb_valid never set.
//  2 LB/LBU/LH/LHU @8, rdata=0x3FE -> wb_data 0xFFFFFFFE / 0xFE / 0x3FE / 0x3FE; wb_rd=0x14.
//  3 SB 0xFFFFFFFF @13 -> mem_addr=0xC, wstrb=0010, wdata=0xFFFFFFFF; SH @14 -> wstrb=1100.
//  4 gnt delayed 3 cycles, rvalid 2 cycles later -> mem_* stable while waiting; busy=1 throughout;
//    single wb pulse.
//  5 rst asserted during WAIT, then spurious rvalid -> mem_req=0, busy=0 at once; no wb_valid.
//  6 (macro on) LW @0x6 -> misalign=1 for 1 cycle, mem_req stays 0; (macro off) LW @0x6 -> mem_addr=0x4.

Source files
------------

// File: rtl/rv32i_pkg.sv
// RV32I load/store constants, LSU state encoding and request classification helpers.
// Ports: none (package).
// Shared by load_store_unit and lsu_align.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;

  // Legal load: LB/LH/LW/LBU/LHU. Legal store: SB/SH/SW.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Access size lives in funct3[1:0]: 01 = half, 10 = word.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/gnt/rvalid bus between the LSU (master) and data memory (slave).
// Signals: req/we/addr/wstrb/wdata from master; gnt/rvalid/rdata from slave.
// req and its payload are held stable until gnt.
interface load_store_unit_if;
  import rv32i_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wstrb, wdata,
                  input  gnt, rvalid, rdata);
  modport slave  (input  req, we, addr, wstrb, wdata,
                  output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replicated data and load byte/half extraction+extension.
// Ports: i_st_* (store funct3, byte offset, rs2) -> o_st_strb/o_st_data;
//        i_ld_* (load funct3, byte offset, read word) -> o_ld_data.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]      i_st_funct3,
  input  logic [1:0]      i_st_off,
  input  logic [XLEN-1:0] i_st_data,
  output logic [3:0]      o_st_strb,
  output logic [XLEN-1:0] o_st_data,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_off,
  input  logic [XLEN-1:0] i_ld_rdata,
  output logic [XLEN-1:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_strb = 4'b1111;
    o_st_data = i_st_data;
    case (i_st_funct3[1:0])
      2'b00: begin
        o_st_strb = 4'b0001 << i_st_off;
        o_st_data = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        // halfword lane comes from addr[1] only; addr[0] is ignored here
        o_st_strb = 4'b0011 << {i_st_off[1], 1'b0};
        o_st_data = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte = i_ld_rdata[{i_ld_off, 3'b000} +: 8];
  assign w_half = i_ld_rdata[{i_ld_off[1], 4'b0000} +: 16];

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_funct3)
      F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_ld_data = {24'h0, w_byte};
      F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_ld_data = {16'h0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time, IDLE->REQ->WAIT->IDLE, loads return a 1-cycle wb pulse.
// Ports: clk/rst; i_req_* core request (o_req_ready in IDLE); mem bus interface (master);
//        o_wb_* load write-back; o_busy stall; o_misalign only when LSU_MISALIGN_TRAP_EN is defined.
module load_store_unit
  import rv32i_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [XLEN-1:0]       i_req_addr,
  input  logic [XLEN-1:0]       i_req_wdata,
  input  logic [REG_ADDR_W-1:0] i_req_rd,
  load_store_unit_if.master     mem,
  output logic                  o_wb_valid,
  output logic [REG_ADDR_W-1:0] o_wb_rd,
  output logic [XLEN-1:0]       o_wb_data,
  output logic                  o_busy
`ifdef LSU_MISALIGN_TRAP_EN
  ,output logic                 o_misalign
`endif
);

  lsu_state_t            r_state, w_next;
  logic                  r_we, r_skip;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_mem_addr, r_mem_wdata;
  logic [3:0]            r_mem_wstrb;
  logic                  r_wb_valid;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [XLEN-1:0]       r_wb_data;
  logic                  w_accept, w_skip, w_misal, w_mem_req;
  logic [3:0]            w_st_strb;
  logic [XLEN-1:0]       w_st_data, w_ld_data;

  assign w_accept = i_req_valid && (r_state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_misal    = f3_legal(i_req_we, i_req_funct3) &&
                      addr_misaligned(i_req_funct3, i_req_addr[1:0]);
  assign o_misalign = r_misalign;
`else
  assign w_misal = 1'b0;
`endif
  // Skipped accesses spend their single busy cycle in REQ with mem_req held low.
  assign w_skip = !f3_legal(i_req_we, i_req_funct3) || w_misal;

  lsu_align u_align (
    .i_st_funct3 (i_req_funct3),
    .i_st_off    (i_req_addr[1:0]),
    .i_st_data   (i_req_wdata),
    .o_st_strb   (w_st_strb),
    .o_st_data   (w_st_data),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_off),
    .i_ld_rdata  (mem.rdata),
    .o_ld_data   (w_ld_data)
  );

  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = REQ;
      REQ: begin
        if (r_skip) begin
          w_next = IDLE;
        end else begin
          w_mem_req = 1'b1;
          if (mem.gnt) w_next = WAIT;
        end
      end
      WAIT: if (mem.rvalid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_skip      <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_rd        <= '0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= 4'b0000;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      r_state    <= w_next;
      r_wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign <= w_accept && w_misal;
`endif
      if (w_accept) begin
        r_we        <= i_req_we;
        r_skip      <= w_skip;
        r_funct3    <= i_req_funct3;
        r_off       <= i_req_addr[1:0];
        r_rd        <= i_req_rd;
        r_mem_addr  <= {i_req_addr[XLEN-1:2], 2'b00};
        r_mem_wstrb <= i_req_we ? w_st_strb : 4'b0000;
        r_mem_wdata <= w_st_data;
      end
      // stores treat rvalid as an ack only
      if (r_state == WAIT && mem.rvalid && !r_we) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= w_ld_data;
      end
    end
  end

  assign mem.req     = w_mem_req;
  assign mem.we      = r_we;
  assign mem.addr    = r_mem_addr;
  assign mem.wstrb   = r_mem_wstrb;
  assign mem.wdata   = r_mem_wdata;
  assign o_req_ready = (r_state == IDLE);
  assign o_busy      = (r_state != IDLE);
  assign o_wb_valid  = r_wb_valid;
  assign o_wb_rd     = r_wb_rd;
  assign o_wb_data   = r_wb_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: bus and write-back expectations queued at drive time,
// popped by a negedge monitor. Exercises LSU_MISALIGN_TRAP_EN paths when that macro is defined.
module tb_load_store_unit;
  import rv32i_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr, i_req_wdata;
  logic [4:0]  i_req_rd;
  logic        o_req_ready, o_wb_valid, o_busy;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bus_t q_bus[$];
  wb_t  q_wb[$];

  load_store_unit_if mem_bus();

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .i_req_rd     (i_req_rd),
    .mem          (mem_bus.master),
    .o_wb_valid   (o_wb_valid),
    .o_wb_rd      (o_wb_rd),
    .o_wb_data    (o_wb_data),
    .o_busy       (o_busy)
`ifdef LSU_MISALIGN_TRAP_EN
    ,.o_misalign  (o_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
  endfunction

  function automatic logic m_misal(input logic we, input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    if (!m_legal(we, f3)) return 1'b0;
    if (f3[1:0] == 2'b01) return a[0];
    if (f3[1:0] == 2'b10) return a[1:0] != 2'b00;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_strb(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!we) return 4'b0000;
    case (f3)
      3'd0:    return 4'(1 << a[1:0]);
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'd1:    return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mem_bus.req && mem_bus.gnt) begin
      if (q_bus.size() == 0) begin
        chk("bus_unexpected", 32'd1, 32'd0);
      end else begin
        bus_t e;
        e = q_bus.pop_front();
        chk("bus_we", {31'd0, mem_bus.we}, {31'd0, e.we});
        chk("bus_addr", mem_bus.addr, e.addr);
        chk("bus_wstrb", {28'd0, mem_bus.wstrb}, {28'd0, e.strb});
        if (e.we) chk("bus_wdata", mem_bus.wdata, e.wdata);
      end
    end
    if (o_wb_valid) begin
      if (q_wb.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t w;
        w = q_wb.pop_front();
        chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, w.rd});
        chk("wb_data", o_wb_data, w.data);
      end
    end
  end

  // ---------------- driver: call at posedge+1 with the LSU idle ----------------
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input int gdly, input int rvdly, input logic [31:0] rdata);
    logic skip;
    logic [31:0] exp_addr;
    bus_t eb;
    wb_t  ew;
    skip     = !m_legal(we, f3) || m_misal(we, f3, a);
    exp_addr = {a[31:2], 2'b00};
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
    i_req_addr = a; i_req_wdata = wd; i_req_rd = rd;
    chk("req_ready", {31'd0, o_req_ready}, 32'd1);
    if (!skip) begin
      eb.we = we; eb.addr = exp_addr; eb.strb = m_strb(we, f3, a); eb.wdata = m_wdata(f3, wd);
      q_bus.push_back(eb);
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    if (skip) begin
      chk("skip_no_req", {31'd0, mem_bus.req}, 32'd0);
      chk("skip_busy", {31'd0, o_busy}, 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("misalign_pulse", {31'd0, o_misalign}, {31'd0, m_misal(we, f3, a)});
`endif
      @(posedge clk); #1;
      chk("skip_idle", {31'd0, o_busy}, 32'd0);
      chk("skip_no_req2", {31'd0, mem_bus.req}, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("misalign_clear", {31'd0, o_misalign}, 32'd0);
`endif
      return;
    end
    for (int i = 0; i < gdly; i++) begin
      chk("hold_req", {31'd0, mem_bus.req}, 32'd1);
      chk("hold_addr", mem_bus.addr, exp_addr);
      chk("hold_wstrb", {28'd0, mem_bus.wstrb}, {28'd0, m_strb(we, f3, a)});
      chk("hold_busy", {31'd0, o_busy}, 32'd1);
      @(posedge clk); #1;
    end
    chk("req_high", {31'd0, mem_bus.req}, 32'd1);
    mem_bus.gnt = 1'b1;
    @(posedge clk); #1;
    mem_bus.gnt = 1'b0;
    for (int i = 0; i < rvdly - 1; i++) begin
      chk("wait_busy", {31'd0, o_busy}, 32'd1);
      chk("wait_no_req", {31'd0, mem_bus.req}, 32'd0);
      @(posedge clk); #1;
    end
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = rdata;
    if (!we) begin
      ew.rd = rd; ew.data = m_load(f3, a, rdata);
      q_wb.push_back(ew);
    end
    @(posedge clk); #1;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata  = $urandom;
    chk("done_idle", {31'd0, o_busy}, 32'd0);
  endtask

  logic [2:0] ld_f3s [5];

  initial begin
    ld_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_funct3 = 3'd0;
    i_req_addr = 32'd0; i_req_wdata = 32'd0; i_req_rd = 5'd0;
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_req", {31'd0, mem_bus.req}, 32'd0);
    chk("rst_we", {31'd0, mem_bus.we}, 32'd0);
    chk("rst_addr", mem_bus.addr, 32'd0);
    chk("rst_wstrb", {28'd0, mem_bus.wstrb}, 32'd0);
    chk("rst_wdata", mem_bus.wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, o_wb_rd}, 32'd0);
    chk("rst_wb_data", o_wb_data, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("rst_misalign", {31'd0, o_misalign}, 32'd0);
`endif
    rst = 1'b0;

    // stores and loads, minimum latency, back-to-back
    access(1'b1, F3_SW, 32'h8, 32'h3FE, 5'd1, 0, 1, 32'h0);
    access(1'b0, F3_LB,  32'h8, 32'h0, 5'h14, 0, 1, 32'h3FE);
    access(1'b0, F3_LBU, 32'h8, 32'h0, 5'h14, 0, 1, 32'h3FE);
    access(1'b0, F3_LH,  32'h8, 32'h0, 5'h14, 0, 1, 32'h3FE);
    access(1'b0, F3_LHU, 32'h8, 32'h0, 5'h14, 0, 1, 32'h3FE);
    access(1'b0, F3_LW,  32'h8, 32'h0, 5'h03, 0, 1, 32'hDEAD_BEEF);
    access(1'b1, F3_SB, 32'd13, 32'hFFFF_FFFF, 5'd0, 0, 1, 32'h0);
    access(1'b1, F3_SH, 32'd14, 32'h1234_ABCD, 5'd0, 0, 1, 32'h0);
    // delayed gnt and rvalid
    access(1'b0, F3_LH,  32'h22, 32'h0, 5'h1F, 3, 2, 32'h8001_7FFF);
    access(1'b1, F3_SB,  32'h41, 32'h0000_005A, 5'd0, 3, 2, 32'h0);
    // illegal funct3
    access(1'b0, 3'd3, 32'h10, 32'h0, 5'd7, 0, 1, 32'h0);
    access(1'b1, 3'd4, 32'h10, 32'h55, 5'd7, 0, 1, 32'h0);
    // misaligned word: trapped with the macro, word-aligned address without it
    access(1'b0, F3_LW, 32'h6, 32'h0, 5'd9, 0, 1, 32'hCAFE_F00D);
    access(1'b1, F3_SH, 32'h7, 32'hBEEF, 5'd0, 1, 1, 32'h0);

    // spurious gnt/rvalid while idle
    mem_bus.gnt = 1'b1; mem_bus.rvalid = 1'b1;
    @(posedge clk); #1;
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0;
    chk("spurious_idle", {31'd0, o_busy}, 32'd0);

    // random legal traffic
    for (int i = 0; i < 24; i++) begin
      logic        rw;
      logic [2:0]  f3;
      rw = 1'($urandom_range(0, 1));
      f3 = rw ? 3'($urandom_range(0, 2)) : ld_f3s[$urandom_range(0, 4)];
      access(rw, f3, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3),
             $urandom_range(1, 3), $urandom);
    end

    // async reset while waiting for the response
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_funct3 = F3_LW;
    i_req_addr = 32'h100; i_req_rd = 5'd5;
    begin
      bus_t eb;
      eb.we = 1'b0; eb.addr = 32'h100; eb.strb = 4'b0000; eb.wdata = 32'h0;
      q_bus.push_back(eb);
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    mem_bus.gnt = 1'b1;
    @(posedge clk); #1;
    mem_bus.gnt = 1'b0;
    chk("wait_state_busy", {31'd0, o_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, mem_bus.req}, 32'd0);
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_ready", {31'd0, o_req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_bus.rvalid = 1'b0;
    chk("post_rst_idle", {31'd0, o_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_wb", {31'd0, o_wb_valid}, 32'd0);

    chk("sb_bus_empty", q_bus.size(), 32'd0);
    chk("sb_wb_empty", q_wb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
